// File: rtl/op_req_sequencer.sv
// op_req_sequencer
//   Accepts one operand request from the launcher and expands it into
//   per-beat VRF read requests. There is one independent stream per operand
//   queue: queue 0 reads vs1 and queue 1 reads vs2. op_req_ready_o stays low
//   until every selected stream has issued its final beat.
//
// Ports
//   clk_i, rst_ni              clock, asynchronous active-low reset
//   op_req_valid_i/ready_o     request handshake (ready == IDLE)
//   op_req_vs1_i/vs2_i         source registers for queue 0 / queue 1
//   op_req_queue_req_i         bit q set: queue q needs operands
//   op_req_vlB_i               operand length in bytes
//   rd_valid_o/rd_ready_i      per-queue read request handshake
//   rd_addr_o                  per-queue VRF word address (wraps v31 -> v0)
//   rd_nbytes_o                valid bytes in the beat (1..BeatB)
//   rd_last_o                  final beat of the request for that queue
//   busy_o                     request in progress
module op_req_sequencer #(
  parameter  int unsigned VLENB       = 16,
  parameter  int unsigned BeatB       = 8,
  localparam int unsigned BeatsPerReg = VLENB / BeatB,
  localparam int unsigned AddrW       = $clog2(32 * BeatsPerReg),
  localparam int unsigned VlBW        = $clog2(8 * VLENB) + 1,
  localparam int unsigned NbW         = $clog2(BeatB) + 1
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      op_req_valid_i,
  output logic                      op_req_ready_o,
  input  logic [4:0]                op_req_vs1_i,
  input  logic [4:0]                op_req_vs2_i,
  input  logic [1:0]                op_req_queue_req_i,
  input  logic [VlBW-1:0]           op_req_vlB_i,
  output logic [1:0]                rd_valid_o,
  input  logic [1:0]                rd_ready_i,
  output logic [1:0][AddrW-1:0]     rd_addr_o,
  output logic [1:0][NbW-1:0]       rd_nbytes_o,
  output logic [1:0]                rd_last_o,
  output logic                      busy_o
);

  localparam int unsigned OffW = $clog2(BeatB);

  typedef enum logic {
    IDLE,
    BUSY
  } state_e;

  state_e                 state_q;
  logic [1:0][4:0]        vs_q;
  logic [VlBW-1:0]        last_idx_q;   // index of the final beat (N-1)
  logic [NbW-1:0]         tail_q;
  logic [1:0][VlBW-1:0]   cnt_q;
  logic [1:0]             pend_q;

  logic                   accept;
  logic [VlBW:0]          len_round;
  logic [VlBW-1:0]        n_beats;
  logic [OffW-1:0]        len_off;
  logic [NbW-1:0]         tail_new;
  logic [1:0]             pend_new;
  logic [1:0]             hs;
  logic [1:0]             pend_after;

  assign op_req_ready_o = (state_q == IDLE);
  assign busy_o         = (state_q == BUSY);
  assign accept         = op_req_valid_i && op_req_ready_o;

  // N = ceil(vlB / BeatB); one extra bit keeps the rounding add from overflowing.
  assign len_round = {1'b0, op_req_vlB_i} + (VlBW + 1)'(BeatB - 1);
  assign n_beats   = VlBW'(len_round >> OffW);
  assign len_off   = op_req_vlB_i[OffW-1:0];
  // vlB - (N-1)*BeatB: a full beat when vlB is a multiple of BeatB.
  assign tail_new  = (len_off == '0) ? NbW'(BeatB) : NbW'(len_off);
  assign pend_new  = op_req_queue_req_i & {2{n_beats != '0}};

  always_comb begin
    rd_valid_o  = '0;
    rd_addr_o   = '0;
    rd_nbytes_o = '0;
    rd_last_o   = '0;
    hs          = '0;
    pend_after  = pend_q;
    for (int unsigned q = 0; q < 2; q++) begin
      rd_valid_o[q]  = pend_q[q] && (state_q == BUSY);
      // Truncation to AddrW bits gives the wrap from v31 back to v0.
      rd_addr_o[q]   = AddrW'(vs_q[q]) * AddrW'(BeatsPerReg) + AddrW'(cnt_q[q]);
      rd_last_o[q]   = (cnt_q[q] == last_idx_q);
      rd_nbytes_o[q] = rd_last_o[q] ? tail_q : NbW'(BeatB);
      hs[q]          = rd_valid_o[q] && rd_ready_i[q];
      if (hs[q] && rd_last_o[q]) begin
        pend_after[q] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      vs_q       <= '0;
      last_idx_q <= '0;
      tail_q     <= '0;
      cnt_q      <= '0;
      pend_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            vs_q       <= {op_req_vs2_i, op_req_vs1_i};
            last_idx_q <= n_beats - VlBW'(1);
            tail_q     <= tail_new;
            cnt_q      <= '0;
            pend_q     <= pend_new;
            state_q    <= (pend_new != '0) ? BUSY : IDLE;
          end
        end
        BUSY: begin
          for (int unsigned q = 0; q < 2; q++) begin
            if (hs[q]) begin
              cnt_q[q] <= cnt_q[q] + VlBW'(1);
            end
          end
          pend_q <= pend_after;
          if (pend_after == '0) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_op_req_sequencer.sv
// tb_op_req_sequencer
//   Self-checking bench for op_req_sequencer. The reference model keeps, per
//   queue, the list of beats still to be issued (address, byte count, last),
//   built from the request with plain arithmetic. The head of each list is
//   what the DUT must present; an accepted beat pops it.
module tb_op_req_sequencer;

  localparam int unsigned VLENB = 16;
  localparam int unsigned BeatB = 8;
  localparam int unsigned BPR   = VLENB / BeatB;
  localparam int unsigned AddrW = 6;
  localparam int unsigned VlBW  = 8;
  localparam int unsigned NbW   = 4;

  logic                  clk_i = 1'b0;
  logic                  rst_ni = 1'b0;
  logic                  op_req_valid_i = 1'b0;
  logic                  op_req_ready_o;
  logic [4:0]            op_req_vs1_i = '0;
  logic [4:0]            op_req_vs2_i = '0;
  logic [1:0]            op_req_queue_req_i = '0;
  logic [VlBW-1:0]       op_req_vlB_i = '0;
  logic [1:0]            rd_valid_o;
  logic [1:0]            rd_ready_i = '0;
  logic [1:0][AddrW-1:0] rd_addr_o;
  logic [1:0][NbW-1:0]   rd_nbytes_o;
  logic [1:0]            rd_last_o;
  logic                  busy_o;

  op_req_sequencer #(.VLENB(VLENB), .BeatB(BeatB)) dut (
    .clk_i              (clk_i),
    .rst_ni             (rst_ni),
    .op_req_valid_i     (op_req_valid_i),
    .op_req_ready_o     (op_req_ready_o),
    .op_req_vs1_i       (op_req_vs1_i),
    .op_req_vs2_i       (op_req_vs2_i),
    .op_req_queue_req_i (op_req_queue_req_i),
    .op_req_vlB_i       (op_req_vlB_i),
    .rd_valid_o         (rd_valid_o),
    .rd_ready_i         (rd_ready_i),
    .rd_addr_o          (rd_addr_o),
    .rd_nbytes_o        (rd_nbytes_o),
    .rd_last_o          (rd_last_o),
    .busy_o             (busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int unsigned addr;
    int unsigned nb;
    bit          last;
  } beat_t;

  beat_t mq[2][$];
  int n_cmp = 0;
  int n_bad = 0;

  function automatic bit m_idle();
    return (mq[0].size() == 0) && (mq[1].size() == 0);
  endfunction

  function automatic void push_req(int unsigned vs1, int unsigned vs2,
                                   bit [1:0] qr, int unsigned vlb);
    int unsigned n;
    beat_t b;
    n = (vlb + BeatB - 1) / BeatB;
    for (int q = 0; q < 2; q++) begin
      if (qr[q]) begin
        for (int unsigned i = 0; i < n; i++) begin
          b.addr = (((q == 0) ? vs1 : vs2) * BPR + i) % (32 * BPR);
          b.nb   = (i == n - 1) ? vlb - (n - 1) * BeatB : BeatB;
          b.last = (i == n - 1);
          mq[q].push_back(b);
        end
      end
    end
  endfunction

  // Applies the handshakes implied by the currently driven inputs to the
  // model, then moves to the next sampling point (falling edge).
  task automatic advance();
    bit idle;
    idle = m_idle();
    for (int q = 0; q < 2; q++) begin
      if (rst_ni && mq[q].size() != 0 && rd_ready_i[q]) void'(mq[q].pop_front());
    end
    if (rst_ni && idle && op_req_valid_i)
      push_req(op_req_vs1_i, op_req_vs2_i, op_req_queue_req_i, op_req_vlB_i);
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    #1;
    n_cmp++;
    if ({rd_valid_o, op_req_ready_o, busy_o} !== 4'b0010) begin
      n_bad++;
      $display("FAIL reset_state: got valid=%b ready=%b busy=%b want valid=00 ready=1 busy=0",
               rd_valid_o, op_req_ready_o, busy_o);
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
  endtask

  task automatic test_directed();
    int unsigned t_vs1[5] = '{3, 2, 4, 31, 1};
    int unsigned t_vs2[5] = '{5, 9, 7, 0, 30};
    bit [1:0]    t_qr[5]  = '{2'b11, 2'b01, 2'b11, 2'b01, 2'b10};
    int unsigned t_vlb[5] = '{32, 20, 16, 64, 13};
    int          t_hold[5] = '{0, 0, 3, 0, 2};
    for (int k = 0; k < 5; k++) begin
      for (int c = 0; c < 20; c++) begin
        op_req_valid_i     = (c == 0);
        op_req_vs1_i       = (c == 0) ? 5'(t_vs1[k]) : 5'($urandom);
        op_req_vs2_i       = (c == 0) ? 5'(t_vs2[k]) : 5'($urandom);
        op_req_queue_req_i = (c == 0) ? t_qr[k] : 2'($urandom);
        op_req_vlB_i       = (c == 0) ? VlBW'(t_vlb[k]) : VlBW'($urandom);
        rd_ready_i         = {!(c >= 1 && c <= t_hold[k]), 1'b1};
        n_cmp++;
        if ({op_req_ready_o, busy_o} !== {m_idle(), !m_idle()}) begin
          n_bad++;
          $display("FAIL directed%0d_c%0d ready/busy: got %b%b want %b%b",
                   k, c, op_req_ready_o, busy_o, m_idle(), !m_idle());
        end
        for (int q = 0; q < 2; q++) begin
          n_cmp++;
          if (rd_valid_o[q] !== (mq[q].size() != 0)) begin
            n_bad++;
            $display("FAIL directed%0d_c%0d valid%0d: got %b want %b",
                     k, c, q, rd_valid_o[q], mq[q].size() != 0);
          end else if (mq[q].size() != 0) begin
            n_cmp++;
            if ({rd_addr_o[q], rd_nbytes_o[q], rd_last_o[q]} !==
                {AddrW'(mq[q][0].addr), NbW'(mq[q][0].nb), mq[q][0].last}) begin
              n_bad++;
              $display("FAIL directed%0d_c%0d beat%0d: got addr=%0d nb=%0d last=%b want addr=%0d nb=%0d last=%b",
                       k, c, q, rd_addr_o[q], rd_nbytes_o[q], rd_last_o[q],
                       mq[q][0].addr, mq[q][0].nb, mq[q][0].last);
            end
          end
        end
        advance();
      end
    end
    op_req_valid_i = 1'b0;
  endtask

  task automatic test_zero_len();
    for (int c = 0; c < 8; c++) begin
      op_req_valid_i     = 1'b1;
      op_req_vs1_i       = 5'($urandom);
      op_req_vs2_i       = 5'($urandom);
      op_req_queue_req_i = (c < 4) ? 2'b11 : 2'b00;
      op_req_vlB_i       = (c < 4) ? '0 : VlBW'($urandom_range(1, 128));
      rd_ready_i         = 2'($urandom);
      n_cmp++;
      if ({rd_valid_o, op_req_ready_o, busy_o} !== 4'b0010) begin
        n_bad++;
        $display("FAIL zero_len_c%0d: got valid=%b ready=%b busy=%b want valid=00 ready=1 busy=0",
                 c, rd_valid_o, op_req_ready_o, busy_o);
      end
      advance();
    end
    op_req_valid_i = 1'b0;
  endtask

  task automatic test_reset_mid();
    op_req_valid_i     = 1'b1;
    op_req_vs1_i       = 5'd3;
    op_req_vs2_i       = 5'd5;
    op_req_queue_req_i = 2'b11;
    op_req_vlB_i       = VlBW'(32);
    rd_ready_i         = 2'b11;
    advance();
    op_req_valid_i = 1'b0;
    advance();
    advance();
    // Two beats per queue accepted; two remain in the model.
    n_cmp++;
    if (rd_valid_o !== 2'b11 || mq[0].size() != 2) begin
      n_bad++;
      $display("FAIL reset_mid_pre: got valid=%b pending=%0d want valid=11 pending=2",
               rd_valid_o, mq[0].size());
    end
    rst_ni = 1'b0;
    #1;
    n_cmp++;
    if ({rd_valid_o, op_req_ready_o, busy_o} !== 4'b0010) begin
      n_bad++;
      $display("FAIL reset_mid_async: got valid=%b ready=%b busy=%b want valid=00 ready=1 busy=0",
               rd_valid_o, op_req_ready_o, busy_o);
    end
    mq[0].delete();
    mq[1].delete();
    advance();
    rst_ni = 1'b1;
    for (int c = 0; c < 10; c++) begin
      op_req_valid_i     = (c == 4);
      op_req_vs1_i       = 5'd12;
      op_req_queue_req_i = 2'b01;
      op_req_vlB_i       = VlBW'(8);
      rd_ready_i         = 2'b11;
      n_cmp++;
      if ({op_req_ready_o, busy_o} !== {m_idle(), !m_idle()}) begin
        n_bad++;
        $display("FAIL reset_mid_c%0d ready/busy: got %b%b want %b%b",
                 c, op_req_ready_o, busy_o, m_idle(), !m_idle());
      end
      for (int q = 0; q < 2; q++) begin
        n_cmp++;
        if (rd_valid_o[q] !== (mq[q].size() != 0)) begin
          n_bad++;
          $display("FAIL reset_mid_c%0d valid%0d: got %b want %b",
                   c, q, rd_valid_o[q], mq[q].size() != 0);
        end else if (mq[q].size() != 0) begin
          n_cmp++;
          if ({rd_addr_o[q], rd_nbytes_o[q], rd_last_o[q]} !==
              {AddrW'(mq[q][0].addr), NbW'(mq[q][0].nb), mq[q][0].last}) begin
            n_bad++;
            $display("FAIL reset_mid_c%0d beat%0d: got addr=%0d nb=%0d last=%b want addr=%0d nb=%0d last=%b",
                     c, q, rd_addr_o[q], rd_nbytes_o[q], rd_last_o[q],
                     mq[q][0].addr, mq[q][0].nb, mq[q][0].last);
          end
        end
      end
      advance();
    end
    op_req_valid_i = 1'b0;
  endtask

  task automatic test_random_back_to_back();
    for (int c = 0; c < 600; c++) begin
      op_req_valid_i     = ($urandom_range(0, 3) != 0);
      op_req_vs1_i       = 5'($urandom);
      op_req_vs2_i       = 5'($urandom);
      op_req_queue_req_i = 2'($urandom);
      op_req_vlB_i       = VlBW'($urandom_range(0, 128));
      rd_ready_i         = {($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 7)};
      n_cmp++;
      if ({op_req_ready_o, busy_o} !== {m_idle(), !m_idle()}) begin
        n_bad++;
        $display("FAIL random_c%0d ready/busy: got %b%b want %b%b",
                 c, op_req_ready_o, busy_o, m_idle(), !m_idle());
      end
      for (int q = 0; q < 2; q++) begin
        n_cmp++;
        if (rd_valid_o[q] !== (mq[q].size() != 0)) begin
          n_bad++;
          $display("FAIL random_c%0d valid%0d: got %b want %b",
                   c, q, rd_valid_o[q], mq[q].size() != 0);
        end else if (mq[q].size() != 0) begin
          n_cmp++;
          if ({rd_addr_o[q], rd_nbytes_o[q], rd_last_o[q]} !==
              {AddrW'(mq[q][0].addr), NbW'(mq[q][0].nb), mq[q][0].last}) begin
            n_bad++;
            $display("FAIL random_c%0d beat%0d: got addr=%0d nb=%0d last=%b want addr=%0d nb=%0d last=%b",
                     c, q, rd_addr_o[q], rd_nbytes_o[q], rd_last_o[q],
                     mq[q][0].addr, mq[q][0].nb, mq[q][0].last);
          end
        end
      end
      advance();
    end
    op_req_valid_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_zero_len();
    test_reset_mid();
    test_random_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/op_req_sequencer.md
Name: op_req_sequencer

Overview:
- Receiving end of the launcher's operand-request channel (op_req), sitting at the front of the VRF access path.
- Accepts one operand request (vs1, vs2, queue select, vlB) and expands it into per-beat VRF read requests, one independent stream per operand queue.
- Each stream carries word address, valid-byte count and a last flag.
- Holds ready low until every selected stream has issued its final beat.

Parameters:
- VLENB, 16, bytes per vector register.
- BeatB, 8, bytes per VRF word/beat; must divide VLENB; power of two.
- BeatsPerReg, VLENB/BeatB (derived), VRF words per register.
- AddrW, $clog2(32*BeatsPerReg) (derived), VRF word address width.
- VlBW, $clog2(8*VLENB)+1 (derived), width of vlB (LMUL up to 8).
- NbW, $clog2(BeatB)+1 (derived), width of per-beat byte count.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- op_req_valid_i  in  1  operand request valid.
- op_req_ready_o  out  1  request accepted when valid&ready.
- op_req_vs1_i  in  5  source register for queue 0.
- op_req_vs2_i  in  5  source register for queue 1.
- op_req_queue_req_i  in  2  bit q=1: queue q needs operands.
- op_req_vlB_i  in  VlBW  byte length of the operand.
- rd_valid_o  out  2  per-queue read request valid.
- rd_ready_i  in  2  per-queue read request ready.
- rd_addr_o  out  2xAddrW  per-queue VRF word address.
- rd_nbytes_o  out  2xNbW  valid bytes in this beat (1..BeatB).
- rd_last_o  out  2  final beat of this request for the queue.
- busy_o  out  1  request in progress.

Behaviour:
- Reset (async, rst_ni=0): state IDLE; rd_valid_o=0, busy_o=0, op_req_ready_o=1; counters cleared. Reset mid-request drops it silently; no further beats after release.
- States: IDLE, BUSY. op_req_ready_o = (state==IDLE). busy_o = (state==BUSY).
- IDLE, valid&ready:
  - latch vs1, vs2 and queue_req;
  - total beats N = ceil(vlB/BeatB);
  - tail bytes = vlB - (N-1)*BeatB;
  - per-queue beat counter = 0; pend[q] = queue_req[q] && N!=0.
  - If no pend bit is set (vlB=0 or queue_req=0): stay IDLE, emit nothing.
  - Else go BUSY next cycle.
- Latency: request accepted in cycle T gives first rd_valid_o in cycle T+1; no combinational path from op_req_* to rd_*.
- BUSY, per queue q:
  - rd_valid_o[q] = pend[q];
  - rd_addr_o[q] = (vs_q*BeatsPerReg + cnt[q]) mod 2^AddrW, i.e. wraps past v31 to v0;
  - rd_last_o[q] = (cnt[q]==N-1);
  - rd_nbytes_o[q] = last ? tail : BeatB.
- On rd_valid_o[q]&rd_ready_i[q]: cnt[q]++; if last, pend[q] clears.
- Queues progress independently; backpressure on one queue never stalls the other.
- Valid holds and addr/nbytes/last stay stable while a beat is unaccepted (AXI-style).
- Final handshake of the last pending queue (both queues may finish in the same cycle): state returns to IDLE next cycle, ready=1 there. Back-to-back requests therefore have one idle bubble.
- rd_addr_o, rd_nbytes_o and rd_last_o are don't-care when the matching rd_valid_o=0.
- rd_ready_i asserted while rd_valid_o=0 has no effect.

Test Plan:
- vs1=3, vs2=5, queue_req=2'b11, vlB=32, rd_ready=11 -> each queue issues 4 beats on consecutive cycles from T+1. Addrs q0 6,7,8,9; q1 10,11,12,13. nbytes all 8; last on 4th beat; ready=1 at T+5.
- vlB=20, queue_req=01, vs1=2 -> q0 addrs 4,5,6; nbytes 8,8,4; last on addr 6; rd_valid_o[1] never asserted.
- queue_req=11, vlB=16, rd_ready_i[1] low for 3 cycles -> q0 completes in 2 cycles; q1 holds addr/valid stable, then finishes; ready only after q1's last beat.
- vlB=0, queue_req=11 -> no rd_valid_o, busy_o stays 0, op_req_ready_o=1 every cycle.
- vs1=31, vlB=64, queue_req=01 -> addrs 62,63,0,1,2,3,4,5 (wrap); last on addr 5.
- Assert rst_ni=0 after 2 of 4 beats -> rd_valid_o=0 immediately; after release no stale beats; new request vlB=8 issues exactly one beat.
